// File: rtl/sensor_monitor.sv
// sensor_monitor: synchronises an N-channel sensor bank, evaluates a
// critical/pair fault rule, filters it for FILTER_CYCLES consecutive cycles,
// and latches a sticky, software-clearable error with source snapshot and
// a saturating fault tally.
module sensor_monitor #(
  parameter int NUM_SENSORS   = 4,
  parameter int PRIMARY_IDX   = 1,
  parameter int FILTER_CYCLES = 3,
  parameter int CNT_W         = 8
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic [NUM_SENSORS-1:0] sensors,
  input  logic [NUM_SENSORS-1:0] crit_mask,
  input  logic [NUM_SENSORS-1:0] pair_mask,
  input  logic                   clear_error,
  output logic                   error,
  output logic                   pending,
  output logic [NUM_SENSORS-1:0] fault_src,
  output logic [CNT_W-1:0]       fault_count
);

  localparam int CNT_BITS = $clog2(FILTER_CYCLES) + 1;
  // Count value at which one more raw cycle completes the filter window.
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(FILTER_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_FAULT   = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [CNT_BITS-1:0]      cnt_q, cnt_d;
  logic [NUM_SENSORS-1:0]   sync1_q, sync1_d;
  logic [NUM_SENSORS-1:0]   sync2_q, sync2_d;
  logic [NUM_SENSORS-1:0]   fault_src_q, fault_src_d;
  logic [CNT_W-1:0]         fault_count_q, fault_count_d;
  logic                     raw;
  logic                     enter_fault;

  // Two-stage synchroniser; nothing downstream looks at sync1 or raw pins.
  always_comb begin
    sync1_d = sensors;
    sync2_d = sync1_q;
  end

  // Raw rule: any critical channel alone, or the primary together with any
  // pair channel. Masks are used live, unregistered.
  assign raw = (|(sync2_q & crit_mask)) |
               (sync2_q[PRIMARY_IDX] & (|(sync2_q & pair_mask)));

  // Next-state, filter counter, snapshot and tally update.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    fault_src_d   = fault_src_q;
    fault_count_d = fault_count_q;
    enter_fault   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (raw) begin
          if (FILTER_CYCLES == 1) begin
            state_d     = ST_FAULT;
            cnt_d       = '0;
            enter_fault = 1'b1;
          end else begin
            state_d = ST_PENDING;
            cnt_d   = CNT_BITS'(1);
          end
        end
      end
      ST_PENDING: begin
        if (!raw) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = ST_FAULT;
          cnt_d       = '0;
          enter_fault = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_BITS'(1);
        end
      end
      ST_FAULT: begin
        // A clear is honoured only once the fault condition has gone away.
        if (clear_error && !raw) begin
          state_d     = ST_IDLE;
          fault_src_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (enter_fault) begin
      fault_src_d = sync2_q;
      if (fault_count_q != {CNT_W{1'b1}}) begin
        fault_count_d = fault_count_q + CNT_W'(1);
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      sync1_q       <= '0;
      sync2_q       <= '0;
      fault_src_q   <= '0;
      fault_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      fault_src_q   <= fault_src_d;
      fault_count_q <= fault_count_d;
    end
  end

  assign error       = (state_q == ST_FAULT);
  assign pending     = (state_q == ST_PENDING);
  assign fault_src   = fault_src_q;
  assign fault_count = fault_count_q;

endmodule

// File: tb/tb_sensor_monitor.sv
// Testbench for sensor_monitor: three instances (default, 2-bit tally,
// single-cycle filter) exercised by scenario tasks with a scoreboard of
// expected fault snapshots / tallies.
module tb_sensor_monitor;

  logic       clk = 1'b0;
  logic       n_rst;

  // Default instance: N=4, PRIMARY_IDX=1, F=3, CNT_W=8
  logic [3:0] sensors_m, crit_m, pair_m;
  logic       clear_m, error_m, pending_m;
  logic [3:0] fault_src_m;
  logic [7:0] fault_count_m;

  // Saturation instance: CNT_W=2
  logic [3:0] sensors_s, crit_s, pair_s;
  logic       clear_s, error_s, pending_s;
  logic [3:0] fault_src_s;
  logic [1:0] fault_count_s;

  // Single-cycle filter instance: FILTER_CYCLES=1
  logic [3:0] sensors_f, crit_f, pair_f;
  logic       clear_f, error_f, pending_f;
  logic [3:0] fault_src_f;
  logic [7:0] fault_count_f;

  typedef struct {
    logic [3:0] src;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  sensor_monitor u_dut (
    .clk(clk), .n_rst(n_rst), .sensors(sensors_m), .crit_mask(crit_m),
    .pair_mask(pair_m), .clear_error(clear_m), .error(error_m),
    .pending(pending_m), .fault_src(fault_src_m), .fault_count(fault_count_m)
  );

  sensor_monitor #(.CNT_W(2)) u_sat (
    .clk(clk), .n_rst(n_rst), .sensors(sensors_s), .crit_mask(crit_s),
    .pair_mask(pair_s), .clear_error(clear_s), .error(error_s),
    .pending(pending_s), .fault_src(fault_src_s), .fault_count(fault_count_s)
  );

  sensor_monitor #(.FILTER_CYCLES(1)) u_f1 (
    .clk(clk), .n_rst(n_rst), .sensors(sensors_f), .crit_mask(crit_f),
    .pair_mask(pair_f), .clear_error(clear_f), .error(error_f),
    .pending(pending_f), .fault_src(fault_src_f), .fault_count(fault_count_f)
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    n_rst = 1'b0;
    tick(); tick(); tick();
    checks += 4;
    if (error_m !== 1'b0) begin failures++; $display("FAIL reset_error got=%b exp=0", error_m); end
    if (pending_m !== 1'b0) begin failures++; $display("FAIL reset_pending got=%b exp=0", pending_m); end
    if (fault_src_m !== 4'b0000) begin failures++; $display("FAIL reset_src got=%b exp=0000", fault_src_m); end
    if (fault_count_m !== 8'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", fault_count_m); end
    n_rst = 1'b1;
    tick(); tick();
    checks++;
    if (error_m !== 1'b0 || pending_m !== 1'b0) begin
      failures++; $display("FAIL post_reset_idle got=%b%b exp=00", error_m, pending_m);
    end
    // Drive into FAULT, then reset between edges.
    sensors_m = 4'b0110;
    for (int i = 0; i < 20 && error_m !== 1'b1; i++) tick();
    checks++;
    if (error_m !== 1'b1) begin failures++; $display("FAIL reset_fault_timeout got=%b exp=1", error_m); end
    $display("reset scenario: faulted count=%0d, pulsing n_rst", fault_count_m);
    n_rst = 1'b0;
    sensors_m = 4'b0000;
    #2;
    checks += 4;
    if (error_m !== 1'b0) begin failures++; $display("FAIL async_reset_error got=%b exp=0", error_m); end
    if (pending_m !== 1'b0) begin failures++; $display("FAIL async_reset_pending got=%b exp=0", pending_m); end
    if (fault_src_m !== 4'b0000) begin failures++; $display("FAIL async_reset_src got=%b exp=0000", fault_src_m); end
    if (fault_count_m !== 8'd0) begin failures++; $display("FAIL async_reset_count got=%0d exp=0", fault_count_m); end
    #1;
    n_rst = 1'b1;
    tick(); tick(); tick();
    e.src = 4'b0; // keep e used
  endtask

  task automatic test_pair_fault();
    exp_t e;
    logic exp_pend[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic exp_err[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    sb_q.push_back('{4'b0110, 8'd1});
    sensors_m = 4'b0110;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks += 2;
      if (pending_m !== exp_pend[k]) begin failures++; $display("FAIL pair_pending edge=%0d got=%b exp=%b", k, pending_m, exp_pend[k]); end
      if (error_m !== exp_err[k]) begin failures++; $display("FAIL pair_error edge=%0d got=%b exp=%b", k, error_m, exp_err[k]); end
    end
    checks++;
    if (error_m === 1'b1 && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      $display("pair fault: src=%b count=%0d", fault_src_m, fault_count_m);
      checks++;
      if (fault_src_m !== e.src) begin failures++; $display("FAIL pair_src got=%b exp=%b", fault_src_m, e.src); end
      if (fault_count_m !== e.cnt) begin failures++; $display("FAIL pair_count got=%0d exp=%0d", fault_count_m, e.cnt); end
    end else begin
      failures++; $display("FAIL pair_no_fault got=%b exp=1", error_m);
    end
    sensors_m = 4'b0000;
    tick(); tick();
    clear_m = 1'b1; tick(); clear_m = 1'b0;
    checks += 3;
    if (error_m !== 1'b0) begin failures++; $display("FAIL pair_clear_error got=%b exp=0", error_m); end
    if (fault_src_m !== 4'b0000) begin failures++; $display("FAIL pair_clear_src got=%b exp=0000", fault_src_m); end
    if (fault_count_m !== 8'd1) begin failures++; $display("FAIL pair_clear_count got=%0d exp=1", fault_count_m); end
  endtask

  task automatic test_glitch();
    logic pend_seen;
    logic err_seen;
    sensors_m = 4'b0001;
    tick(); tick();
    sensors_m = 4'b0000;
    pend_seen = 1'b0;
    err_seen  = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      pend_seen |= pending_m;
      err_seen  |= error_m;
    end
    $display("glitch crit: pending_seen=%b error_seen=%b count=%0d", pend_seen, err_seen, fault_count_m);
    checks += 3;
    if (pend_seen !== 1'b1) begin failures++; $display("FAIL glitch_pending got=%b exp=1", pend_seen); end
    if (err_seen !== 1'b0) begin failures++; $display("FAIL glitch_error got=%b exp=0", err_seen); end
    if (fault_count_m !== 8'd1) begin failures++; $display("FAIL glitch_count got=%0d exp=1", fault_count_m); end
    // Pair channels without the primary are not a fault.
    sensors_m = 4'b1100;
    pend_seen = 1'b0;
    err_seen  = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      pend_seen |= pending_m;
      err_seen  |= error_m;
    end
    sensors_m = 4'b0000;
    $display("glitch pair-no-primary: pending_seen=%b error_seen=%b", pend_seen, err_seen);
    checks += 2;
    if (pend_seen !== 1'b0) begin failures++; $display("FAIL noprim_pending got=%b exp=0", pend_seen); end
    if (err_seen !== 1'b0) begin failures++; $display("FAIL noprim_error got=%b exp=0", err_seen); end
    tick(); tick(); tick();
  endtask

  task automatic test_clear_rules();
    exp_t e;
    sb_q.push_back('{4'b0001, 8'd2});
    sensors_m = 4'b0001;
    for (int i = 0; i < 20 && error_m !== 1'b1; i++) tick();
    checks++;
    if (error_m === 1'b1 && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      $display("clear scenario: fault src=%b count=%0d", fault_src_m, fault_count_m);
      checks++;
      if (fault_src_m !== e.src) begin failures++; $display("FAIL clear_src got=%b exp=%b", fault_src_m, e.src); end
      if (fault_count_m !== e.cnt) begin failures++; $display("FAIL clear_count got=%0d exp=%0d", fault_count_m, e.cnt); end
    end else begin
      failures++; $display("FAIL clear_fault_timeout got=%b exp=1", error_m);
    end
    clear_m = 1'b1; tick(); clear_m = 1'b0;
    checks++;
    if (error_m !== 1'b1) begin failures++; $display("FAIL clear_while_raw got=%b exp=1", error_m); end
    tick();
    checks++;
    if (error_m !== 1'b1) begin failures++; $display("FAIL clear_while_raw_hold got=%b exp=1", error_m); end
    sensors_m = 4'b0000;
    tick(); tick();
    clear_m = 1'b1; tick(); clear_m = 1'b0;
    checks += 3;
    if (error_m !== 1'b0) begin failures++; $display("FAIL clear_ok_error got=%b exp=0", error_m); end
    if (fault_src_m !== 4'b0000) begin failures++; $display("FAIL clear_ok_src got=%b exp=0000", fault_src_m); end
    if (fault_count_m !== 8'd2) begin failures++; $display("FAIL clear_ok_count got=%0d exp=2", fault_count_m); end
  endtask

  task automatic test_saturation();
    exp_t e;
    for (int i = 0; i < 5; i++) sb_q.push_back('{4'b0001, (i < 3) ? 8'(i + 1) : 8'd3});
    for (int i = 0; i < 5; i++) begin
      sensors_s = 4'b0001;
      for (int j = 0; j < 20 && error_s !== 1'b1; j++) tick();
      checks++;
      if (error_s === 1'b1 && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        $display("saturation fault %0d: count=%0d src=%b", i, fault_count_s, fault_src_s);
        checks++;
        if (fault_count_s !== e.cnt[1:0]) begin failures++; $display("FAIL sat_count idx=%0d got=%0d exp=%0d", i, fault_count_s, e.cnt[1:0]); end
        if (fault_src_s !== e.src) begin failures++; $display("FAIL sat_src idx=%0d got=%b exp=%b", i, fault_src_s, e.src); end
      end else begin
        failures++; $display("FAIL sat_timeout idx=%0d got=%b exp=1", i, error_s);
      end
      sensors_s = 4'b0000;
      tick(); tick();
      clear_s = 1'b1; tick(); clear_s = 1'b0;
      checks++;
      if (error_s !== 1'b0) begin failures++; $display("FAIL sat_clear idx=%0d got=%b exp=0", i, error_s); end
    end
  endtask

  task automatic test_f1();
    exp_t e;
    logic pend_seen;
    sb_q.push_back('{4'b0001, 8'd1});
    sensors_f = 4'b0001;
    pend_seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      pend_seen |= pending_f;
      checks++;
      if (error_f !== (k >= 2)) begin failures++; $display("FAIL f1_error edge=%0d got=%b exp=%b", k, error_f, (k >= 2)); end
      if (k == 2 && error_f === 1'b1 && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        $display("f1 fault: src=%b count=%0d", fault_src_f, fault_count_f);
        checks += 2;
        if (fault_src_f !== e.src) begin failures++; $display("FAIL f1_src got=%b exp=%b", fault_src_f, e.src); end
        if (fault_count_f !== e.cnt) begin failures++; $display("FAIL f1_count got=%0d exp=%0d", fault_count_f, e.cnt); end
      end
    end
    checks += 2;
    if (pend_seen !== 1'b0) begin failures++; $display("FAIL f1_pending got=%b exp=0", pend_seen); end
    if (sb_q.size() != 0) begin failures++; $display("FAIL sb_leftover got=%0d exp=0", sb_q.size()); end
  endtask

  initial begin
    sensors_m = '0; crit_m = 4'b0001; pair_m = 4'b1100; clear_m = 1'b0;
    sensors_s = '0; crit_s = 4'b0001; pair_s = 4'b1100; clear_s = 1'b0;
    sensors_f = '0; crit_f = 4'b0001; pair_f = 4'b1100; clear_f = 1'b0;
    n_rst = 1'b0;
    #1;
    test_reset();
    test_pair_fault();
    test_glitch();
    test_clear_rules();
    test_saturation();
    test_f1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
